// File: rtl/seg7_pkg.sv
// Glyph encodings, item codes and the per-item message table
// shared by the seven-segment item scroller.
package seg7_pkg;

   typedef logic [6:0] glyph_t;

   localparam glyph_t GLY_BLANK = 7'b1111111;
   localparam glyph_t GLY_A     = 7'b0001000;
   localparam glyph_t GLY_B     = 7'b0000011;
   localparam glyph_t GLY_C     = 7'b1000110;
   localparam glyph_t GLY_D     = 7'b0100001;
   localparam glyph_t GLY_E     = 7'b0000110;
   localparam glyph_t GLY_F     = 7'b0001110;
   localparam glyph_t GLY_H     = 7'b0001001;
   localparam glyph_t GLY_I     = 7'b1001111;
   localparam glyph_t GLY_L     = 7'b1000111;
   localparam glyph_t GLY_N     = 7'b0101011;
   localparam glyph_t GLY_O     = 7'b1000000;
   localparam glyph_t GLY_P     = 7'b0001100;
   localparam glyph_t GLY_R     = 7'b0101111;
   localparam glyph_t GLY_S     = 7'b0010010;
   localparam glyph_t GLY_T     = 7'b0000111;

   localparam logic [2:0] ITEM_TABLE = 3'b000;
   localparam logic [2:0] ITEM_PEN   = 3'b001;
   localparam logic [2:0] ITEM_BAD0  = 3'b010;
   localparam logic [2:0] ITEM_DOLL  = 3'b011;
   localparam logic [2:0] ITEM_FISH  = 3'b100;
   localparam logic [2:0] ITEM_CHAIR = 3'b101;
   localparam logic [2:0] ITEM_HAT   = 3'b110;
   localparam logic [2:0] ITEM_BAD1  = 3'b111;

   function automatic logic item_valid(input logic [2:0] upc);
      return !((upc == ITEM_BAD0) || (upc == ITEM_BAD1));
   endfunction

   // Slots past the end of a message, and undefined items, read blank.
   function automatic glyph_t msg_glyph(input logic [2:0] upc,
                                        input int unsigned slot);
      glyph_t g;
      g = GLY_BLANK;
      case (upc)
         ITEM_TABLE:
            case (slot)
               0: g = GLY_T;
               1: g = GLY_A;
               2: g = GLY_B;
               3: g = GLY_L;
               4: g = GLY_E;
               default: g = GLY_BLANK;
            endcase
         ITEM_PEN:
            case (slot)
               0: g = GLY_P;
               1: g = GLY_E;
               2: g = GLY_N;
               default: g = GLY_BLANK;
            endcase
         ITEM_DOLL:
            case (slot)
               0: g = GLY_D;
               1: g = GLY_O;
               2: g = GLY_L;
               3: g = GLY_L;
               default: g = GLY_BLANK;
            endcase
         ITEM_FISH:
            case (slot)
               0: g = GLY_F;
               1: g = GLY_I;
               2: g = GLY_S;
               3: g = GLY_H;
               default: g = GLY_BLANK;
            endcase
         ITEM_CHAIR:
            case (slot)
               0: g = GLY_C;
               1: g = GLY_H;
               2: g = GLY_A;
               3: g = GLY_I;
               4: g = GLY_R;
               default: g = GLY_BLANK;
            endcase
         ITEM_HAT:
            case (slot)
               0: g = GLY_H;
               1: g = GLY_A;
               2: g = GLY_T;
               default: g = GLY_BLANK;
            endcase
         default: g = GLY_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_item_scroller_tick_gen.sv
// Step divider: pulses tick once every TICK_DIV clocks;
// clr restarts the count so a new item gets a full first step.
module tick_gen #(
   parameter int TICK_DIV = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_max;

   assign w_at_max = (r_cnt == CNT_MAX);
   assign tick     = w_at_max;

   // Free-running modulo-TICK_DIV counter with restart.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_cnt <= '0;
      end else if (w_at_max) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg7_item_scroller.sv
// Item-code message display: static, marquee-scrolled or blinked
// across NUM_DIGITS active-low HEX digits, with registered outputs.
module seg7_item_scroller
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int MSG_LEN    = 8,
   parameter int TICK_DIV   = 25000000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [2:0]                   upc,
   input  logic                         scroll_en,
   input  logic                         blink_en,
   output logic [NUM_DIGITS-1:0][6:0]   hex,
   output logic                         valid,
   output logic [$clog2(MSG_LEN)-1:0]   pos
);

   localparam int OFF_W = $clog2(MSG_LEN);
   localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(MSG_LEN - 1);

   logic [2:0]                 r_upc_q;
   logic [OFF_W-1:0]           r_off;
   logic                       r_hid;
   logic [NUM_DIGITS-1:0][6:0] r_hex;
   logic                       r_valid;

   logic                       w_chg;
   logic                       w_tick_raw;
   logic                       w_tick;
   logic [NUM_DIGITS-1:0][6:0] w_hex;

   // Both addends are below MSG_LEN, so one subtract wraps the ring.
   function automatic int unsigned slot_of(input logic [OFF_W-1:0] off,
                                           input int d);
      int s;
      s = int'(off) + (NUM_DIGITS - 1 - d);
      if (s >= MSG_LEN) begin
         s = s - MSG_LEN;
      end
      return $unsigned(s);
   endfunction

   assign w_chg  = (upc != r_upc_q);
   assign w_tick = w_tick_raw && !w_chg;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (w_chg),
      .tick  (w_tick_raw)
   );

   // Item latch plus scroll offset and blink phase sequencing.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_upc_q <= 3'b000;
         r_off   <= '0;
         r_hid   <= 1'b0;
      end else begin
         r_upc_q <= upc;
         if (w_chg || !scroll_en) begin
            r_off <= '0;
         end else if (w_tick) begin
            r_off <= (r_off == OFF_MAX) ? '0 : r_off + 1'b1;
         end
         if (w_chg || !blink_en) begin
            r_hid <= 1'b0;
         end else if (w_tick) begin
            r_hid <= !r_hid;
         end
      end
   end

   // Select the glyph window for the current offset and phase.
   always_comb begin
      w_hex = '1;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         w_hex[d] = r_hid ? GLY_BLANK
                          : msg_glyph(r_upc_q, slot_of(r_off, d));
      end
   end

   // Register the segment drive and item-valid flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hex   <= '1;
         r_valid <= 1'b0;
      end else begin
         r_hex   <= w_hex;
         r_valid <= item_valid(r_upc_q);
      end
   end

   assign hex   = r_hex;
   assign valid = r_valid;
   assign pos   = r_off;

endmodule
